// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit; sole owner of the HI/LO register pair.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic [3:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Result datapath works only from the latched operands, so A/B may change freely while busy.
    always_comb begin
        prod_s  = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
        prod_u  = {32'd0, a_reg} * {32'd0, b_reg};

        // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
        dvd_neg = (op_reg == OP_DIV) && a_reg[31];
        dvs_neg = (op_reg == OP_DIV) && b_reg[31];
        dvd_mag = dvd_neg ? (~a_reg + 32'd1) : a_reg;
        dvs_mag = dvs_neg ? (~b_reg + 32'd1) : b_reg;
        if (b_reg == 32'd0) begin
            dvs_mag = 32'd1;
        end
        q_mag   = dvd_mag / dvs_mag;
        r_mag   = dvd_mag % dvs_mag;
        quot    = (dvd_neg ^ dvs_neg) ? (~q_mag + 32'd1) : q_mag;
        rem     = dvd_neg ? (~r_mag + 32'd1) : r_mag;

        res_we  = 1'b1;
        res_hi  = hi_reg;
        res_lo  = lo_reg;
        case (op_reg)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_reg == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi_reg, lo_reg} + prod_s;
            OP_MADDU: {res_hi, res_lo} = {hi_reg, lo_reg} + prod_u;
            OP_MSUB:  {res_hi, res_lo} = {hi_reg, lo_reg} - prod_s;
            OP_MSUBU: {res_hi, res_lo} = {hi_reg, lo_reg} - prod_u;
`endif
            default:  res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= 5'd0;
            op_reg    <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
`ifdef MDU_MADD_EN
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
                            OP_MULT, OP_MULTU: begin
`endif
                                state_reg <= ST_BUSY;
                                count_reg <= MULT_N;
                                op_reg    <= op;
                                a_reg     <= A;
                                b_reg     <= B;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_reg <= ST_BUSY;
                                count_reg <= DIV_N;
                                op_reg    <= op;
                                a_reg     <= A;
                                b_reg     <= B;
                            end
                            OP_MTHI: hi_reg <= A;
                            OP_MTLO: lo_reg <= A;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Any start arriving here is dropped on purpose; the hazard unit should never issue one.
                    count_reg <= count_reg - 5'd1;
                    if (count_reg == 5'd1) begin
                        state_reg <= ST_IDLE;
                        if (res_we) begin
                            hi_reg <= res_hi;
                            lo_reg <= res_lo;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_BUSY);
    assign HI   = hi_reg;
    assign LO   = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases followed by random ops against an arithmetic model.
// Expectations for ops 7-10 follow MDU_MADD_EN the same way the design build does.
module tb_mult_div_unit;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO become and how many busy cycles the op should take.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] nhi, output logic [31:0] nlo, output int ncyc);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        logic [63:0] acc;
        sa  = a;
        sb  = b;
        sp  = longint'(sa) * longint'(sb);
        up  = {32'd0, a} * {32'd0, b};
        acc = {hi, lo};
        nhi = hi;
        nlo = lo;
        ncyc = 0;
        case (o)
            4'd1: begin {nhi, nlo} = sp; ncyc = MULT_CYCLES; end
            4'd2: begin {nhi, nlo} = up; ncyc = MULT_CYCLES; end
            4'd3: begin
                ncyc = DIV_CYCLES;
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        nlo = 32'h8000_0000;
                        nhi = 32'd0;
                    end else begin
                        nlo = sa / sb;
                        nhi = sa % sb;
                    end
                end
            end
            4'd4: begin
                ncyc = DIV_CYCLES;
                if (b != 32'd0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
            4'd5: nhi = a;
            4'd6: nlo = a;
`ifdef MDU_MADD_EN
            4'd7:  begin {nhi, nlo} = acc + sp; ncyc = MULT_CYCLES; end
            4'd8:  begin {nhi, nlo} = acc + up; ncyc = MULT_CYCLES; end
            4'd9:  begin {nhi, nlo} = acc - sp; ncyc = MULT_CYCLES; end
            4'd10: begin {nhi, nlo} = acc - up; ncyc = MULT_CYCLES; end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op from idle, scramble inputs (including stray starts) while busy, then check the result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nhi;
        logic [31:0] nlo;
        int          ncyc;
        int          cnt;
        model(o, a, b, exp_hi, exp_lo, nhi, nlo, ncyc);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; op = 4'd0;
        if (ncyc == 0) begin
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end else begin
            chk({tag, "_busy_on"}, 32'(busy), 32'd1);
            chk({tag, "_hi_held"}, HI, exp_hi);
            cnt = 0;
            while (busy === 1'b1 && cnt < 64) begin
                cnt++;
                A = $urandom; B = $urandom;
                start = 1'($urandom_range(0, 1));
                op = 4'($urandom_range(0, 10));
                tick();
            end
            start = 1'b0; op = 4'd0;
            chk({tag, "_cycles"}, 32'(cnt), 32'(ncyc));
        end
        chk({tag, "_hi"}, HI, nhi);
        chk({tag, "_lo"}, LO, nlo);
        $display("op=%0d A=%h B=%h -> HI=%h LO=%h (%s)", o, a, b, HI, LO, tag);
        exp_hi = nhi;
        exp_lo = nlo;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        // Reset in the middle of a divide discards it.
        run_op("pre_mthi", 4'd5, 32'hAAAA_5555, 32'd0);
        run_op("pre_mtlo", 4'd6, 32'h5555_AAAA, 32'd0);
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; op = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        repeat (15) tick();
        chk("midrst_late_busy", 32'(busy), 32'd0);
        chk("midrst_late_lo", LO, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", LO, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_const", HI, 32'h0000_0002);
        chk("multu_lo_const", LO, 32'hFFFF_FFFA);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_const", LO, 32'hFFFF_FFFD);
        chk("div_hi_const", HI, 32'hFFFF_FFFF);
        run_op("divu", 4'd4, 32'd7, 32'd2);
        chk("divu_lo_const", LO, 32'd3);
        chk("divu_hi_const", HI, 32'd1);

        run_op("mthi", 4'd5, 32'h1234_5678, 32'd0);
        run_op("mtlo", 4'd6, 32'h9ABC_DEF0, 32'd0);
        run_op("div0", 4'd3, 32'd55, 32'd0);
        chk("div0_hi_const", HI, 32'h1234_5678);
        chk("div0_lo_const", LO, 32'h9ABC_DEF0);

        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", LO, 32'h8000_0000);
        chk("div_ovf_hi_const", HI, 32'd0);

        // Start of a div during cycle 2 of a mult must be dropped.
        start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0; op = 4'd0;
        tick();
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; op = 4'd0;
        cnt = 3;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            tick();
        end
        chk("overlap_cycles", 32'(cnt - 1), 32'd5);
        chk("overlap_hi", HI, 32'd0);
        chk("overlap_lo", LO, 32'd12);
        repeat (12) tick();
        chk("overlap_late_busy", 32'(busy), 32'd0);
        chk("overlap_late_lo", LO, 32'd12);
        exp_hi = 32'd0;
        exp_lo = 32'd12;

        run_op("madd_pre_hi", 4'd5, 32'd0, 32'd0);
        run_op("madd_pre_lo", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op("madd", 4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("madd_hi_const", HI, 32'd1);
        chk("madd_lo_const", LO, 32'd0);
`else
        chk("madd_hi_const", HI, 32'd0);
        chk("madd_lo_const", LO, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 4'($urandom_range(0, 12));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
